// File: rtl/buf_arb_pkg.sv
// -----------------------------------------------------------------------------
// buf_arb_pkg
// Shared definitions for the buffer write-port arbiter:
//   - state_e      : arbiter FSM encoding (IDLE=0, GRANT=1)
//   - clog2()      : constant-width helper for index and counter sizing
//   - DEF_*        : default parameter values for buf_wr_arbiter
// -----------------------------------------------------------------------------
package buf_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_MAX_BURST = 16;
  localparam int DEF_TIMEOUT   = 32;

  // Ceiling log2 for elaboration-time width calculation; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result++;
      rem = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Purely combinational round-robin picker. Searches req_i starting at
// last_grant_i + 1 and wrapping, so the previous winner has lowest priority.
// Ports:
//   req_i        : request vector, one bit per requester
//   last_grant_i : index of the most recently released owner
//   found_o      : at least one request is set
//   index_o      : winning requester index (0 when found_o = 0)
// -----------------------------------------------------------------------------
module rr_pick
  import buf_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  localparam int IDX_W  = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_grant_i,
  output logic               found_o,
  output logic [IDX_W-1:0]   index_o
);

  logic             hit;
  logic [IDX_W-1:0] hit_idx;
  logic [IDX_W-1:0] cand_idx;
  int               cand;

  // Walk the offsets 1..NUM_REQ from the last owner; the first hit wins.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    cand     = 0;
    cand_idx = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = int'(last_grant_i) + off;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!hit && req_i[cand_idx]) begin
        hit     = 1'b1;
        hit_idx = cand_idx;
      end
    end
  end

  assign found_o = hit;
  assign index_o = hit_idx;

endmodule

// File: rtl/buf_wr_arbiter.sv
// -----------------------------------------------------------------------------
// buf_wr_arbiter
// Round-robin arbiter sharing the byte buffer's single write port among
// NUM_REQ packet sources. A grant is held for a whole packet; beat data is
// muxed combinationally onto the buffer write interface. A burst cap and an
// idle timeout prevent one source from holding the port forever.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   req_valid    : per-requester beat valid
//   req_last     : per-requester last beat of packet
//   req_data     : per-requester data, requester i at [i*DATA_W +: DATA_W]
//   req_ready    : per-requester beat accepted (owner only, when not full)
//   buf_full     : buffer full flag
//   buf_wr_en    : buffer write strobe (never high while buf_full)
//   buf_data     : buffer write data (owner's data)
//   grant_valid  : a requester owns the port (registered)
//   grant_id     : owner index (registered)
//   burst_trunc  : one-cycle pulse, grant released by MAX_BURST
//   timeout      : one-cycle pulse, grant released by TIMEOUT
// -----------------------------------------------------------------------------
module buf_wr_arbiter
  import buf_arb_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = DEF_MAX_BURST,
  parameter int TIMEOUT   = DEF_TIMEOUT,
  localparam int ID_W     = clog2(NUM_REQ),
  localparam int BCNT_W   = clog2(MAX_BURST + 1),
  localparam int ICNT_W   = clog2(TIMEOUT + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_last,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      buf_full,
  output logic                      buf_wr_en,
  output logic [DATA_W-1:0]         buf_data,
  output logic                      grant_valid,
  output logic [ID_W-1:0]           grant_id,
  output logic                      burst_trunc,
  output logic                      timeout
);

  state_e             state_q, state_d;
  logic [ID_W-1:0]    grant_id_q, grant_id_d;
  logic [ID_W-1:0]    last_grant_q, last_grant_d;
  logic [BCNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [ICNT_W-1:0]  idle_cnt_q, idle_cnt_d;
  logic               burst_trunc_q, burst_trunc_d;
  logic               timeout_q, timeout_d;

  logic               pick_found;
  logic [ID_W-1:0]    pick_idx;
  logic [DATA_W-1:0]  data_arr [NUM_REQ];
  logic               owner_valid;
  logic               owner_last;
  logic               beat;
  logic               release_grant;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req_i        (req_valid),
    .last_grant_i (last_grant_q),
    .found_o      (pick_found),
    .index_o      (pick_idx)
  );

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      data_arr[i] = req_data[i*DATA_W +: DATA_W];
    end
  end

  assign owner_valid = req_valid[grant_id_q];
  assign owner_last  = req_last[grant_id_q];
  assign buf_data    = data_arr[grant_id_q];

  always_comb begin
    state_d       = state_q;
    grant_id_d    = grant_id_q;
    last_grant_d  = last_grant_q;
    beat_cnt_d    = beat_cnt_q;
    idle_cnt_d    = idle_cnt_q;
    burst_trunc_d = 1'b0;
    timeout_d     = 1'b0;
    req_ready     = '0;
    beat          = 1'b0;
    release_grant = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Arbitration cycle: no beat moves here, the grant registers below.
        if (pick_found) begin
          grant_id_d = pick_idx;
          state_d    = ST_GRANT;
        end
      end
      ST_GRANT: begin
        req_ready[grant_id_q] = !buf_full;
        beat                  = owner_valid && !buf_full;
        if (beat) begin
          idle_cnt_d = '0;
          if (beat_cnt_q < BCNT_W'(MAX_BURST)) beat_cnt_d = beat_cnt_q + 1'b1;
          // A last beat landing exactly on the cap is a normal end of packet.
          if (owner_last) begin
            release_grant = 1'b1;
          end else if (beat_cnt_d == BCNT_W'(MAX_BURST)) begin
            release_grant = 1'b1;
            burst_trunc_d = 1'b1;
          end
        end else if (!owner_valid) begin
          // Backpressure stalls (valid && full) fall through and hold the count.
          idle_cnt_d = idle_cnt_q + 1'b1;
          if (idle_cnt_d == ICNT_W'(TIMEOUT)) begin
            release_grant = 1'b1;
            timeout_d     = 1'b1;
          end
        end
        if (release_grant) begin
          state_d      = ST_IDLE;
          last_grant_d = grant_id_q;
          beat_cnt_d   = '0;
          idle_cnt_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Reset drops the grant in the same cycle, not one cycle later.
    if (rst) begin
      req_ready = '0;
      beat      = 1'b0;
    end
  end

  assign buf_wr_en = beat;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      grant_id_q    <= '0;
      last_grant_q  <= ID_W'(NUM_REQ - 1);
      beat_cnt_q    <= '0;
      idle_cnt_q    <= '0;
      burst_trunc_q <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_id_q    <= grant_id_d;
      last_grant_q  <= last_grant_d;
      beat_cnt_q    <= beat_cnt_d;
      idle_cnt_q    <= idle_cnt_d;
      burst_trunc_q <= burst_trunc_d;
      timeout_q     <= timeout_d;
    end
  end

  assign grant_valid = (state_q == ST_GRANT);
  assign grant_id    = grant_id_q;
  assign burst_trunc = burst_trunc_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_buf_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_buf_wr_arbiter
// Directed scenarios followed by random traffic. The driver advances a
// cycle-level behavioural model and pushes the expected outputs of each cycle
// into a queue; a monitor on the falling edge pops and compares.
// -----------------------------------------------------------------------------
module tb_buf_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 16;
  localparam int TO = 32;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_last;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            buf_full;
  logic            buf_wr_en;
  logic [DW-1:0]   buf_data;
  logic            grant_valid;
  logic [1:0]      grant_id;
  logic            burst_trunc;
  logic            timeout;

  logic [DW-1:0]   src_data [N];

  assign req_data = {src_data[3], src_data[2], src_data[1], src_data[0]};

  buf_wr_arbiter #(
    .NUM_REQ   (N),
    .DATA_W    (DW),
    .MAX_BURST (MB),
    .TIMEOUT   (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_last    (req_last),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .buf_full    (buf_full),
    .buf_wr_en   (buf_wr_en),
    .buf_data    (buf_data),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .burst_trunc (burst_trunc),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]  ready;
    logic          wr;
    logic [DW-1:0] data;
    logic          gv;
    logic [1:0]    gid;
    logic          bt;
    logic          to;
  } exp_t;

  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;
  int obs_trunc = 0;
  int obs_to    = 0;
  int obs_wr    = 0;

  // Reference model: who owns the port, whose turn is next, and how many
  // beats / idle cycles the current packet has used.
  int m_owner = -1;
  int m_last  = N - 1;
  int m_gid   = 0;
  int m_beats = 0;
  int m_idle  = 0;
  bit m_trunc = 1'b0;
  bit m_to    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last  = N - 1;
    m_gid   = 0;
    m_beats = 0;
    m_idle  = 0;
    m_trunc = 1'b0;
    m_to    = 1'b0;
  endtask

  // Predict this cycle's outputs from the current inputs, queue them, then
  // advance the model across the coming clock edge.
  task automatic step();
    exp_t e;
    int   g;
    bit   rel;
    e.gv    = (m_owner >= 0);
    e.gid   = 2'(m_gid);
    e.bt    = m_trunc;
    e.to    = m_to;
    e.ready = '0;
    e.wr    = 1'b0;
    e.data  = '0;
    rel     = 1'b0;
    if (rst) begin
      model_reset();
    end else begin
      m_trunc = 1'b0;
      m_to    = 1'b0;
      if (m_owner < 0) begin
        for (int k = 1; k <= N; k++) begin
          int r;
          r = (m_last + k) % N;
          if (m_owner < 0 && req_valid[r]) begin
            m_owner = r;
            m_gid   = r;
          end
        end
      end else begin
        g = m_owner;
        if (!buf_full) e.ready[g] = 1'b1;
        if (req_valid[g] && !buf_full) begin
          e.wr   = 1'b1;
          e.data = src_data[g];
          m_beats++;
          m_idle = 0;
          if (req_last[g]) rel = 1'b1;
          else if (m_beats == MB) begin
            rel     = 1'b1;
            m_trunc = 1'b1;
          end
        end else if (!req_valid[g]) begin
          m_idle++;
          if (m_idle == TO) begin
            rel  = 1'b1;
            m_to = 1'b1;
          end
        end
        if (rel) begin
          m_owner = -1;
          m_last  = g;
          m_beats = 0;
          m_idle  = 0;
        end
      end
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Monitor: compare every presented cycle against the queued expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("req_ready",   32'(req_ready),   32'(e.ready));
      check("buf_wr_en",   32'(buf_wr_en),   32'(e.wr));
      if (e.wr) check("buf_data", 32'(buf_data), 32'(e.data));
      check("grant_valid", 32'(grant_valid), 32'(e.gv));
      check("grant_id",    32'(grant_id),    32'(e.gid));
      check("burst_trunc", 32'(burst_trunc), 32'(e.bt));
      check("timeout",     32'(timeout),     32'(e.to));
      if (buf_wr_en === 1'b1 && buf_full === 1'b1) check("wr_while_full", 32'd1, 32'd0);
      if (burst_trunc === 1'b1) obs_trunc++;
      if (timeout === 1'b1)     obs_to++;
      if (buf_wr_en === 1'b1)   obs_wr++;
    end
  end

  task automatic idle_inputs();
    req_valid = '0;
    req_last  = '0;
    buf_full  = 1'b0;
  endtask

  initial begin
    int base_to, base_tr, base_wr;
    rst       = 1'b1;
    idle_inputs();
    for (int i = 0; i < N; i++) src_data[i] = '0;
    @(posedge clk);
    #1;

    // Reset state, then a 3-beat packet from requester 0.
    steps(2);
    rst = 1'b0;
    base_wr = obs_wr;
    req_valid = 4'b0001; src_data[0] = 8'hA1; step();
    step();
    src_data[0] = 8'hA2; step();
    src_data[0] = 8'hA3; req_last = 4'b0001; step();
    idle_inputs(); steps(2);
    check("pkt0_writes", 32'(obs_wr - base_wr), 32'd3);

    // All requesters busy, single-beat packets: rotating grants.
    req_valid = 4'b1111; req_last = 4'b1111;
    for (int i = 0; i < 12; i++) begin
      for (int j = 0; j < N; j++) src_data[j] = 8'(16 * j + i);
      step();
    end
    idle_inputs(); step();

    // Requester 2 with idle gaps and a 10-cycle backpressure stall.
    base_to = obs_to;
    req_valid = 4'b0100; src_data[2] = 8'h55; step();
    step();
    req_valid = '0; steps(25);
    req_valid = 4'b0100; src_data[2] = 8'h66; buf_full = 1'b1; steps(10);
    buf_full = 1'b0; req_valid = '0; steps(3);
    req_valid = 4'b0100; req_last = 4'b0100; step();
    idle_inputs(); steps(2);
    check("stall_no_timeout", 32'(obs_to - base_to), 32'd0);

    // Requester 1 streams without last; requester 2 waits behind it.
    base_tr = obs_trunc;
    req_valid = 4'b0110; req_last = 4'b0100; src_data[2] = 8'hC2;
    for (int i = 0; i < 19; i++) begin
      src_data[1] = 8'(8'h10 + i);
      step();
    end
    idle_inputs(); steps(2);
    check("burst_trunc_count", 32'(obs_trunc - base_tr), 32'd1);

    // Requester 3 granted, then goes silent.
    base_to = obs_to;
    base_wr = obs_wr;
    req_valid = 4'b1000; src_data[3] = 8'hD3; step();
    req_valid = '0; steps(36);
    check("timeout_count", 32'(obs_to - base_to), 32'd1);
    check("timeout_no_write", 32'(obs_wr - base_wr), 32'd0);

    // Reset in the middle of a packet.
    req_valid = 4'b0001; src_data[0] = 8'hE1; step();
    step();
    src_data[0] = 8'hE2; rst = 1'b1; step();
    rst = 1'b0; req_valid = 4'b1001; src_data[3] = 8'hF3; step();
    req_last = 4'b1001; step();
    idle_inputs(); steps(2);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 299) == 0);
      buf_full  = ($urandom_range(0, 3) == 0);
      req_valid = 4'($urandom_range(0, 15) | $urandom_range(0, 15));
      req_last  = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      for (int j = 0; j < N; j++) src_data[j] = 8'($urandom);
      step();
    end
    rst = 1'b0;
    idle_inputs(); steps(2);

    @(negedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
